// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: PC width, FSM states and update-queue entry.
package branch_resolve_unit_pkg;

    localparam int PC_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
    } uq_entry_t;

endpackage

// File: rtl/branch_resolve_unit_uq.sv
// Coalescing circular FIFO of pending BTB writes; an incoming PC already queued
// (and not leaving as the head this cycle) has its target overwritten instead of pushing.
module btb_update_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int UQ_DEPTH = 4,
    localparam int PW = $clog2(UQ_DEPTH),
    localparam int OW = PW + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid_i,
    input  uq_entry_t  wr_entry_i,
    input  logic       pop_i,
    output uq_entry_t  head_o,
    output logic [OW-1:0] occ_o
);

    uq_entry_t       mem_q [UQ_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [OW-1:0]   occ_q, occ_d;

    logic [UQ_DEPTH-1:0] match_vec;
    logic                push;
    logic [PW-1:0]       offset;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        match_vec = '0;
        offset    = '0;
        for (int i = 0; i < UQ_DEPTH; i++) begin
            offset = PW'(i) - head_q;
            match_vec[i] = ({1'b0, offset} < occ_q)
                        && (mem_q[i].pc == wr_entry_i.pc)
                        && !(pop_i && (PW'(i) == head_q));
        end
    end

    assign push = wr_valid_i && (match_vec == '0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (pop_i) begin
            head_d = (head_q == PW'(UQ_DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (push) begin
            tail_d = (tail_q == PW'(UQ_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        occ_d = occ_q + OW'(push) - OW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < UQ_DEPTH; i++) begin
            if (wr_valid_i && match_vec[i]) begin
                mem_q[i].target <= wr_entry_i.target;
            end else if (push && (PW'(i) == tail_q)) begin
                mem_q[i] <= wr_entry_i;
            end
        end
    end

    assign head_o = (occ_q == '0) ? '0 : mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches against fetch's prediction, issues a registered redirect plus a
// refill flush window, and feeds corrected entries to the BTB through the update queue.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int UQ_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                resolve_valid,
    output logic                resolve_ready,
    input  logic [PC_WIDTH-1:0] resolve_pc,
    input  logic                resolve_taken,
    input  logic [PC_WIDTH-1:0] resolve_target,
    input  logic                pred_hit,
    input  logic [PC_WIDTH-1:0] pred_target,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush,
    input  logic                btb_wr_ready,
    output logic                is_req_pc,
    output logic [PC_WIDTH-1:0] req_pc,
    output logic [PC_WIDTH-1:0] predict_target,
    output logic [31:0]         mispredict_cnt
);

    localparam int OW = $clog2(UQ_DEPTH) + 1;

    bru_state_e          state_q;
    logic [7:0]          flush_cnt_q;
    logic                redir_q;
    logic                flush_q;
    logic [PC_WIDTH-1:0] redir_pc_q;
    logic [31:0]         cnt_q, cnt_d;

    logic [PC_WIDTH-1:0] seq_pc, act_pc;
    logic                mispredict, upd_need, accept, pop;
    logic [OW-1:0]       uq_occ;
    logic                uq_full, uq_empty;
    uq_entry_t           wr_entry, head;

    assign seq_pc     = resolve_pc + PC_WIDTH'(4);
    assign act_pc     = resolve_taken ? resolve_target : seq_pc;
    assign mispredict = (pred_target != act_pc);
    // Not-taken after a hit also lands here, overwriting the stale entry with pc+4.
    assign upd_need   = mispredict || (resolve_taken && !pred_hit);

    assign uq_full       = (uq_occ == OW'(UQ_DEPTH));
    assign uq_empty      = (uq_occ == '0);
    assign resolve_ready = (state_q == IDLE) && !uq_full;
    assign accept        = resolve_valid && resolve_ready;
    assign pop           = !uq_empty && btb_wr_ready;

    assign wr_entry.pc     = resolve_pc;
    assign wr_entry.target = act_pc;

    btb_update_queue #(.UQ_DEPTH(UQ_DEPTH)) u_uq (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (accept && upd_need),
        .wr_entry_i (wr_entry),
        .pop_i      (pop),
        .head_o     (head),
        .occ_o      (uq_occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            redir_q     <= 1'b0;
            flush_q     <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    redir_q <= 1'b0;
                    flush_q <= 1'b0;
                    if (accept && mispredict) begin
                        state_q    <= REDIR;
                        redir_q    <= 1'b1;
                        flush_q    <= 1'b1;
                        redir_pc_q <= act_pc;
                    end
                end
                REDIR: begin
                    redir_q     <= 1'b0;
                    flush_cnt_q <= 8'(FLUSH_CYCLES);
                    if (FLUSH_CYCLES == 0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Leave as the counter reaches zero so the window spans REDIR + FLUSH_CYCLES.
                    flush_cnt_q <= flush_cnt_q - 8'd1;
                    if (flush_cnt_q <= 8'd1) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    redir_q <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;
    assign flush          = flush_q;
    assign is_req_pc      = pop;
    assign req_pc         = head.pc;
    assign predict_target = head.target;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scenarios plus randomized traffic checked against a cycle-level queue/window model.
module tb_branch_resolve_unit;

    localparam int UQ = 4;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv, rtk, phit, bwr;
    logic [31:0] rpc, rtgt, ptgt;
    logic        resolve_ready, redirect_valid, flush, is_req_pc;
    logic [31:0] redirect_pc, req_pc, predict_target, mispredict_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [31:0] pc; logic [31:0] tg; } ent_t;
    ent_t        mq[$];
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_flush;
    logic [31:0] m_cnt;

    branch_resolve_unit #(.UQ_DEPTH(UQ), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .resolve_valid(rv), .resolve_ready(resolve_ready),
        .resolve_pc(rpc), .resolve_taken(rtk), .resolve_target(rtgt),
        .pred_hit(phit), .pred_target(ptgt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .btb_wr_ready(bwr), .is_req_pc(is_req_pc), .req_pc(req_pc),
        .predict_target(predict_target), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model applies the same inputs the DUT samples at the edge.
    task automatic tick();
        bit acc, pop, mis, upd;
        logic [31:0] act;
        int idx;
        acc = rv && (m_flush == 0) && (mq.size() < UQ);
        pop = (mq.size() > 0) && bwr;
        act = rtk ? rtgt : rpc + 32'd4;
        mis = (ptgt != act);
        upd = mis || (rtk && !phit);
        @(posedge clk);
        if (reset) begin
            mq.delete(); m_redir = 0; m_rpc = 0; m_flush = 0; m_cnt = 0;
        end else begin
            idx = -1;
            if (acc && upd)
                for (int i = pop ? 1 : 0; i < mq.size(); i++)
                    if (mq[i].pc == rpc) idx = i;
            if (acc && upd && idx >= 0) mq[idx].tg = act;
            if (pop) void'(mq.pop_front());
            if (acc && upd && idx < 0) mq.push_back('{rpc, act});
            if (acc && mis) begin
                m_redir = 1; m_rpc = act; m_flush = 1 + FC;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end else begin
                m_redir = 0;
                if (m_flush > 0) m_flush--;
            end
        end
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                        input logic hit, input logic [31:0] pt);
        rv = 1; rpc = pc; rtk = tk; rtgt = tg; phit = hit; ptgt = pt;
        tick();
        rv = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick(); reset = 0;
        tests++; if (resolve_ready !== 1'b1) begin fails++; $display("FAIL reset.ready got %0b want 1", resolve_ready); end
        tests++; if ({redirect_valid, flush, is_req_pc} !== 3'b000) begin fails++; $display("FAIL reset.flags got %b want 000", {redirect_valid, flush, is_req_pc}); end
        tests++; if ({redirect_pc, req_pc, predict_target, mispredict_cnt} !== 128'd0) begin fails++; $display("FAIL reset.values got %h/%h/%h/%h want 0", redirect_pc, req_pc, predict_target, mispredict_cnt); end
    endtask

    task automatic test_correct();
        bwr = 1;
        send(32'h100, 1, 32'h200, 1, 32'h200);
        tests++; if ({redirect_valid, flush, is_req_pc} !== 3'b000) begin fails++; $display("FAIL correct.flags got %b want 000", {redirect_valid, flush, is_req_pc}); end
        tests++; if (mispredict_cnt !== 32'd0) begin fails++; $display("FAIL correct.cnt got %0d want 0", mispredict_cnt); end
    endtask

    task automatic test_cold();
        send(32'h100, 1, 32'h200, 0, 32'h104);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin fails++; $display("FAIL cold.redirect got %0b/%h want 1/00000200", redirect_valid, redirect_pc); end
        tests++; if (is_req_pc !== 1'b1 || req_pc !== 32'h100 || predict_target !== 32'h200) begin fails++; $display("FAIL cold.write got %0b %h->%h want 1 100->200", is_req_pc, req_pc, predict_target); end
        tests++; if (mispredict_cnt !== 32'd1) begin fails++; $display("FAIL cold.cnt got %0d want 1", mispredict_cnt); end
        for (int c = 0; c < 3; c++) begin
            tests++; if (flush !== 1'b1 || resolve_ready !== 1'b0) begin fails++; $display("FAIL cold.window%0d got flush=%0b ready=%0b want 1/0", c, flush, resolve_ready); end
            tick();
        end
        tests++; if (flush !== 1'b0 || resolve_ready !== 1'b1 || redirect_valid !== 1'b0) begin fails++; $display("FAIL cold.end got flush=%0b ready=%0b redir=%0b want 0/1/0", flush, resolve_ready, redirect_valid); end
    endtask

    task automatic test_stale();
        send(32'h300, 0, 32'h999, 1, 32'h400);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin fails++; $display("FAIL stale.redirect got %0b/%h want 1/00000304", redirect_valid, redirect_pc); end
        tests++; if (is_req_pc !== 1'b1 || req_pc !== 32'h300 || predict_target !== 32'h304) begin fails++; $display("FAIL stale.write got %0b %h->%h want 1 300->304", is_req_pc, req_pc, predict_target); end
        tick(); tick(); tick();
        send(32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
        tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin fails++; $display("FAIL stale.wrap got %0b/%h want 1/00000000", redirect_valid, redirect_pc); end
        tick(); tick(); tick();
    endtask

    task automatic test_full();
        bwr = 0;
        for (int k = 0; k < 4; k++) begin
            send(32'h1000 + 32'(k * 16), 1, 32'h2000 + 32'(k * 16), 0, 32'h1004 + 32'(k * 16));
            tick(); tick(); tick();
        end
        tests++; if (resolve_ready !== 1'b0 || is_req_pc !== 1'b0) begin fails++; $display("FAIL full.ready got ready=%0b req=%0b want 0/0", resolve_ready, is_req_pc); end
        bwr = 1; #1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (is_req_pc !== 1'b1 || req_pc !== 32'h1000 + 32'(k * 16) || predict_target !== 32'h2000 + 32'(k * 16)) begin
                fails++; $display("FAIL full.drain%0d got %0b %h->%h want 1 %h->%h", k, is_req_pc, req_pc, predict_target, 32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16)); end
            tick();
        end
        tests++; if (is_req_pc !== 1'b0 || resolve_ready !== 1'b1) begin fails++; $display("FAIL full.empty got req=%0b ready=%0b want 0/1", is_req_pc, resolve_ready); end
    endtask

    task automatic test_coalesce();
        bwr = 0;
        send(32'h100, 1, 32'h200, 0, 32'h104); tick(); tick(); tick();
        send(32'h100, 1, 32'h280, 1, 32'h200); tick(); tick(); tick();
        bwr = 1; #1;
        tests++; if (is_req_pc !== 1'b1 || req_pc !== 32'h100 || predict_target !== 32'h280) begin fails++; $display("FAIL coalesce.head got %0b %h->%h want 1 100->280", is_req_pc, req_pc, predict_target); end
        tick();
        tests++; if (is_req_pc !== 1'b0) begin fails++; $display("FAIL coalesce.single got req=%0b want 0", is_req_pc); end
    endtask

    task automatic test_wrap_reset();
        bwr = 1;
        for (int k = 0; k < 6; k++) begin
            send(32'h500 + 32'(k * 8), 1, 32'h600 + 32'(k * 8), 0, 32'h504 + 32'(k * 8));
            tests++; if (is_req_pc !== 1'b1 || req_pc !== 32'h500 + 32'(k * 8) || predict_target !== 32'h600 + 32'(k * 8)) begin
                fails++; $display("FAIL wrap.write%0d got %0b %h->%h want 1 %h->%h", k, is_req_pc, req_pc, predict_target, 32'h500 + 32'(k * 8), 32'h600 + 32'(k * 8)); end
            if (k < 5) begin tick(); tick(); tick(); end
        end
        tick();
        tests++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin fails++; $display("FAIL wrap.inflush got flush=%0b redir=%0b want 1/0", flush, redirect_valid); end
        reset = 1; tick(); reset = 0;
        tests++; if (resolve_ready !== 1'b1 || {redirect_valid, flush, is_req_pc} !== 3'b000) begin fails++; $display("FAIL wrap.reset got ready=%0b flags=%b want 1/000", resolve_ready, {redirect_valid, flush, is_req_pc}); end
        tests++; if ({redirect_pc, req_pc, predict_target, mispredict_cnt} !== 128'd0) begin fails++; $display("FAIL wrap.resetvals got %h/%h/%h/%h want 0", redirect_pc, req_pc, predict_target, mispredict_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] act, e_req, e_tgt;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            rv    = ($urandom_range(0, 2) != 0);
            rpc   = 32'h100 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            rtk   = $urandom_range(0, 1);
            rtgt  = 32'h800 + 32'($urandom_range(0, 3) * 4);
            act   = rtk ? rtgt : rpc + 32'd4;
            phit  = $urandom_range(0, 1);
            ptgt  = !phit ? rpc + 32'd4 : ($urandom_range(0, 1) ? act : 32'h800 + 32'($urandom_range(0, 3) * 4));
            bwr   = ($urandom_range(0, 2) == 0);
            tick();
            e_req = (mq.size() > 0) ? mq[0].pc : 32'd0;
            e_tgt = (mq.size() > 0) ? mq[0].tg : 32'd0;
            tests++; if (resolve_ready !== ((m_flush == 0) && (mq.size() < UQ))) begin fails++; $display("FAIL rand%0d.ready got %0b want %0b", n, resolve_ready, (m_flush == 0) && (mq.size() < UQ)); end
            tests++; if (redirect_valid !== m_redir || (m_redir && redirect_pc !== m_rpc)) begin fails++; $display("FAIL rand%0d.redirect got %0b/%h want %0b/%h", n, redirect_valid, redirect_pc, m_redir, m_rpc); end
            tests++; if (flush !== (m_flush > 0)) begin fails++; $display("FAIL rand%0d.flush got %0b want %0b", n, flush, m_flush > 0); end
            tests++; if (is_req_pc !== ((mq.size() > 0) && bwr) || req_pc !== e_req || predict_target !== e_tgt) begin
                fails++; $display("FAIL rand%0d.write got %0b %h->%h want %0b %h->%h", n, is_req_pc, req_pc, predict_target, (mq.size() > 0) && bwr, e_req, e_tgt); end
            tests++; if (mispredict_cnt !== m_cnt) begin fails++; $display("FAIL rand%0d.cnt got %0d want %0d", n, mispredict_cnt, m_cnt); end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; rv = 0; rpc = 0; rtk = 0; rtgt = 0; phit = 0; ptgt = 0; bwr = 0;
        m_redir = 0; m_rpc = 0; m_flush = 0; m_cnt = 0;
        test_reset();
        test_correct();
        test_cold();
        test_stale();
        test_full();
        test_coalesce();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
